// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128 key expansion delivering round keys 0..10 over a valid/ack handshake
module aes_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [127:0] Key,
  input  logic         Start,
  input  logic         RoundKeyAck,
  output logic [127:0] RoundKey,
  output logic [3:0]   RoundIdx,
  output logic         RoundKeyValid,
  output logic         Done
);
  typedef enum logic [1:0] {IDLE, OUT, DONE} state_t;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8 * int'(x) -: 8];
  endfunction
  state_t        state_q, state_d;
  logic [127:0]  key_q, key_d, key_nxt;
  logic [3:0]    idx_q, idx_d;
  logic [31:0]   rot, t, w0, w1, w2, w3;
  logic [7:0]    rcon;
  // Rcon for round idx_q+1: doubling for rounds 1..8, then the two reduced values
  assign rcon = idx_q < 4'd8 ? 8'd1 << idx_q[2:0] : idx_q == 4'd8 ? 8'h1b : 8'h36;
  assign rot = {key_q[23:0], key_q[31:24]};
  assign t = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign w0 = key_q[127:96] ^ t;
  assign w1 = key_q[95:64] ^ w0;
  assign w2 = key_q[63:32] ^ w1;
  assign w3 = key_q[31:0] ^ w2;
  assign key_nxt = {w0, w1, w2, w3};
  always_comb begin
    state_d = state_q;
    key_d = key_q;
    idx_d = idx_q;
    if (state_q != OUT && Start) begin
      state_d = OUT;
      key_d = Key;
      idx_d = 4'd0;
    end else if (state_q == OUT && RoundKeyAck) begin
      state_d = idx_q == 4'(NUM_ROUNDS) ? DONE : OUT;
      key_d = idx_q == 4'(NUM_ROUNDS) ? key_q : key_nxt;
      idx_d = idx_q == 4'(NUM_ROUNDS) ? idx_q : idx_q + 4'd1;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      key_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      key_q <= key_d;
      idx_q <= idx_d;
    end
  end
  assign RoundKey = key_q;
  assign RoundIdx = idx_q;
  assign RoundKeyValid = state_q == OUT;
  assign Done = state_q == DONE;
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: directed and randomized checks against a GF(2^8)-derived key expansion model
module tb_aes_key_schedule;
  logic Clk = 0, Rst, Start, RoundKeyAck, RoundKeyValid, Done;
  logic [127:0] Key, RoundKey;
  logic [3:0] RoundIdx;
  int n_chk = 0, n_err = 0;
  logic [7:0] sb [256];
  logic [127:0] ex_key, ex_base;
  int ex_idx;
  logic ex_valid, ex_done;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  aes_key_schedule dut (
    .Clk(Clk), .Rst(Rst), .Key(Key), .Start(Start), .RoundKeyAck(RoundKeyAck),
    .RoundKey(RoundKey), .RoundIdx(RoundIdx), .RoundKeyValid(RoundKeyValid), .Done(Done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xtime(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_key(input logic [127:0] base, input int r);
    logic [31:0] w [4];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int j = 0; j < 4; j++) w[j] = base[127 - 32 * j -: 32];
    for (int j = 1; j <= r; j++) begin
      t = {sb[w[3][23:16]] ^ rc, sb[w[3][15:8]], sb[w[3][7:0]], sb[w[3][31:24]]};
      w[0] ^= t;
      w[1] ^= w[0];
      w[2] ^= w[1];
      w[3] ^= w[2];
      rc = xtime(rc);
    end
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; expected outputs follow the handshake rules
  task automatic step(input logic st, input logic ack, input logic rst, input logic [127:0] k);
    Start = st;
    RoundKeyAck = ack;
    Rst = rst;
    Key = k;
    if (rst) begin
      ex_valid = 0; ex_done = 0; ex_idx = 0; ex_key = '0;
    end else if (!ex_valid && st) begin
      ex_valid = 1; ex_done = 0; ex_idx = 0; ex_base = k; ex_key = k;
    end else if (ex_valid && ack) begin
      if (ex_idx == 10) begin
        ex_valid = 0; ex_done = 1;
      end else begin
        ex_idx++;
        ex_key = model_key(ex_base, ex_idx);
      end
    end
    @(posedge Clk);
    #1;
    check("round_key", RoundKey, ex_key);
    check("round_idx", 128'(RoundIdx), 128'(ex_idx));
    check("valid", 128'(RoundKeyValid), 128'(ex_valid));
    check("done", 128'(Done), 128'(ex_done));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    Rst = 1; Start = 0; RoundKeyAck = 0; Key = '0;
    build_sbox();
    for (int i = 0; i < 3; i++) step(1'($urandom), 1'($urandom), 1, rnd128());
    step(0, 0, 0, rnd128());
    step(1, 1, 0, FIPS_KEY);
    check("fips_r0", RoundKey, FIPS_KEY);
    step(0, 1, 0, rnd128());
    check("fips_r1", RoundKey, FIPS_R1);
    for (int i = 0; i < 9; i++) step(0, 1, 0, rnd128());
    check("fips_r10", RoundKey, FIPS_R10);
    step(0, 1, 0, rnd128());
    check("fips_done", {RoundKeyValid, Done}, 128'b01);
    for (int i = 0; i < 2; i++) step(0, 1, 0, rnd128());
    step(1, 0, 0, FIPS_KEY);
    check("restart_key", RoundKey, FIPS_KEY);
    for (int i = 0; i < 2; i++) step(0, 1, 0, rnd128());
    step(1, 0, 0, rnd128());
    check("start_in_out_idx", 128'(RoundIdx), 128'd2);
    for (int i = 0; i < 2; i++) step(0, 1, 0, rnd128());
    check("pre_reset_idx", 128'(RoundIdx), 128'd4);
    step(0, 1, 1, rnd128());
    check("mid_reset", {RoundKeyValid, RoundIdx}, 128'h0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, rnd128());
    step(1, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, rnd128());
    step(0, 1, 0, rnd128());
    check("zero_r1", RoundKey, ZERO_R1);
    for (int n = 0; n < 4; n++) begin
      step(1, 1'($urandom), 0, rnd128());
      for (int c = 0; c < 80 && !ex_done; c++) begin
        step(1'($urandom), ($urandom % 4) != 0, ($urandom % 64) == 0, rnd128());
        if (!ex_valid && !ex_done) step(1, 0, 0, rnd128());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
